// File: rtl/uart_apb_arbiter.sv
// Purpose : two-master to one-slave APB3 arbiter in front of the UART register map, with round-robin on contention.
// Latency : master setup at cycle 0 -> downstream SETUP at 1 -> ACCESS at 2 -> master pready in the cycle the slave's pready arrives.
// Backpr. : the non-granted master sees pready low and holds its transfer; the granted master waits until the slave's pready arrives.
//
// Ports:
//   i_apb_pclk / i_apb_prst          clock, asynchronous active-high reset
//   i_m_*                            two upstream APB3 masters, bit/slice k = master k
//   o_m_prdata/pready/pslverr        response, routed only to the granted master
//   o_s_*  / i_s_*                   downstream APB3 port to the register map
//   o_grant                          one-hot current owner, 0 when idle
//   o_busy                           a downstream transfer is in progress
// Optional: define UART_APB_ARB_TIMEOUT_EN to end an access phase with pslverr
//           once the slave has stalled for TIMEOUT_CYCLES access cycles.
module uart_apb_arbiter #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        i_apb_pclk,
    input  logic                        i_apb_prst,
    input  logic [1:0]                  i_m_psel,
    input  logic [1:0]                  i_m_penable,
    input  logic [1:0]                  i_m_pwrite,
    input  logic [2*APB_ADDR_WIDTH-1:0] i_m_paddr,
    input  logic [2*APB_DATA_WIDTH-1:0] i_m_pwdata,
    output logic [2*APB_DATA_WIDTH-1:0] o_m_prdata,
    output logic [1:0]                  o_m_pready,
    output logic [1:0]                  o_m_pslverr,
    output logic                        o_s_psel,
    output logic                        o_s_penable,
    output logic                        o_s_pwrite,
    output logic [APB_ADDR_WIDTH-1:0]   o_s_paddr,
    output logic [APB_DATA_WIDTH-1:0]   o_s_pwdata,
    input  logic [APB_DATA_WIDTH-1:0]   i_s_prdata,
    input  logic                        i_s_pready,
    input  logic                        i_s_pslverr,
    output logic [1:0]                  o_grant,
    output logic                        o_busy
);

    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      grant;
    logic            last_grant;   // index of the master served most recently
    logic [1:0]      req;
    logic            win;          // index of the master picked in IDLE
    logic            tmo;
    logic [AW-1:0]   xfer_addr;
    logic [DW-1:0]   xfer_wdata;
    logic            xfer_write;

    // A master requests as soon as psel rises; penable only marks the
    // master-side phase and is not needed to arbitrate or to respond.
    logic unused_penable;
    assign unused_penable = ^i_m_penable;

    assign req = i_m_psel;
    assign win = (req == 2'b11) ? ~last_grant : req[1];

`ifdef UART_APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Counts stalled access cycles; cleared outside ACCESS so every
    // transfer starts from zero at ACCESS entry.
    always_ff @(posedge i_apb_pclk or posedge i_apb_prst) begin
        if (i_apb_prst) begin
            tmo_cnt <= '0;
        end else if (state != ACCESS) begin
            tmo_cnt <= '0;
        end else if (!tmo) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo = (state == ACCESS) && !i_s_pready && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_apb_pclk or posedge i_apb_prst) begin
        if (i_apb_prst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transfer capture: the winner's address/data/direction are frozen at
    // grant time so the downstream bus stays stable through SETUP/ACCESS.
    always_ff @(posedge i_apb_pclk or posedge i_apb_prst) begin
        if (i_apb_prst) begin
            grant      <= 2'b00;
            last_grant <= 1'b1;
            xfer_addr  <= '0;
            xfer_wdata <= '0;
            xfer_write <= 1'b0;
        end else if (state == IDLE && req != 2'b00) begin
            grant      <= win ? 2'b10 : 2'b01;
            xfer_addr  <= win ? i_m_paddr[AW +: AW]  : i_m_paddr[0 +: AW];
            xfer_wdata <= win ? i_m_pwdata[DW +: DW] : i_m_pwdata[0 +: DW];
            xfer_write <= win ? i_m_pwrite[1]        : i_m_pwrite[0];
        end else if (state == ACCESS && (i_s_pready || tmo)) begin
            grant      <= 2'b00;
            last_grant <= grant[1];
            xfer_addr  <= '0;
            xfer_wdata <= '0;
            xfer_write <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_s_psel    = 1'b0;
        o_s_penable = 1'b0;
        o_m_pready  = 2'b00;
        o_m_pslverr = 2'b00;
        o_m_prdata  = '0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                o_s_psel  = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                o_s_psel    = 1'b1;
                o_s_penable = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    if (grant[k]) begin
                        if (tmo) begin
                            o_m_pready[k]  = 1'b1;
                            o_m_pslverr[k] = 1'b1;
                        end else if (i_s_pready && i_m_psel[k]) begin
                            // A master that abandoned its transfer gets no response.
                            o_m_pready[k]             = 1'b1;
                            o_m_pslverr[k]            = i_s_pslverr;
                            o_m_prdata[k*DW +: DW]    = i_s_prdata;
                        end
                    end
                end
                if (i_s_pready || tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_s_paddr  = xfer_addr;
    assign o_s_pwdata = xfer_wdata;
    assign o_s_pwrite = xfer_write;
    assign o_grant    = grant;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Bench for uart_apb_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_uart_apb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      m_psel = '0;
    logic [1:0]      m_penable = '0;
    logic [1:0]      m_pwrite = '0;
    logic [2*AW-1:0] m_paddr = '0;
    logic [2*DW-1:0] m_pwdata = '0;
    logic [DW-1:0]   s_prdata = '0;
    logic            s_pready = 1'b0;
    logic            s_pslverr = 1'b0;

    logic [2*DW-1:0] o_m_prdata;
    logic [1:0]      o_m_pready;
    logic [1:0]      o_m_pslverr;
    logic            o_s_psel;
    logic            o_s_penable;
    logic            o_s_pwrite;
    logic [AW-1:0]   o_s_paddr;
    logic [DW-1:0]   o_s_pwdata;
    logic [1:0]      o_grant;
    logic            o_busy;

    int              checks = 0;
    int              failures = 0;
    bit              cmp_on = 1'b1;
    logic [1:0]      rdy_seen = '0;

    always #5 clk = ~clk;

    uart_apb_arbiter #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .i_apb_pclk (clk),
        .i_apb_prst (rst),
        .i_m_psel   (m_psel),
        .i_m_penable(m_penable),
        .i_m_pwrite (m_pwrite),
        .i_m_paddr  (m_paddr),
        .i_m_pwdata (m_pwdata),
        .o_m_prdata (o_m_prdata),
        .o_m_pready (o_m_pready),
        .o_m_pslverr(o_m_pslverr),
        .o_s_psel   (o_s_psel),
        .o_s_penable(o_s_penable),
        .o_s_pwrite (o_s_pwrite),
        .o_s_paddr  (o_s_paddr),
        .o_s_pwdata (o_s_pwdata),
        .i_s_prdata (s_prdata),
        .i_s_pready (s_pready),
        .i_s_pslverr(s_pslverr),
        .o_grant    (o_grant),
        .o_busy     (o_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // owner: -1 when no transfer is outstanding, else the master being served.
    // age  : cycles since the grant (1 = setup beat, >=2 = access beats).
    int              mdl_owner = -1;
    int              mdl_last  = 1;
    int              mdl_age   = 0;
    logic [AW-1:0]   mdl_addr  = '0;
    logic [DW-1:0]   mdl_wdata = '0;
    logic            mdl_write = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_owner = -1;
            mdl_last  = 1;
            mdl_age   = 0;
        end else if (mdl_owner >= 0) begin
            if (mdl_age >= 2 && s_pready) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
            end else begin
                mdl_age++;
            end
        end else if (m_psel != 2'b00) begin
            if (m_psel == 2'b11) mdl_owner = 1 - mdl_last;
            else                 mdl_owner = m_psel[1] ? 1 : 0;
            mdl_addr  = m_paddr[mdl_owner*AW +: AW];
            mdl_wdata = m_pwdata[mdl_owner*DW +: DW];
            mdl_write = m_pwrite[mdl_owner];
            mdl_age   = 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0]      e_rdy;
        logic [1:0]      e_err;
        logic [1:0]      e_grant;
        logic [2*DW-1:0] e_rdata;
        bit              act;
        bit              done;
        if (cmp_on) begin
            act     = (mdl_owner >= 0);
            done    = act && (mdl_age >= 2) && s_pready;
            e_rdy   = '0;
            e_err   = '0;
            e_grant = '0;
            e_rdata = '0;
            if (act) e_grant[mdl_owner] = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (done && k == mdl_owner && m_psel[k]) begin
                    e_rdy[k]            = 1'b1;
                    e_err[k]            = s_pslverr;
                    e_rdata[k*DW +: DW] = s_prdata;
                end
            end
            chk("grant",     o_grant,     e_grant);
            chk("busy",      o_busy,      act);
            chk("s_psel",    o_s_psel,    act);
            chk("s_penable", o_s_penable, act && mdl_age >= 2);
            chk("s_paddr",   o_s_paddr,   act ? mdl_addr  : '0);
            chk("s_pwdata",  o_s_pwdata,  act ? mdl_wdata : '0);
            chk("s_pwrite",  o_s_pwrite,  act ? mdl_write : 1'b0);
            chk("m_pready",  o_m_pready,  e_rdy);
            chk("m_pslverr", o_m_pslverr, e_err);
            chk("m_prdata",  o_m_prdata,  e_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns 1 ns after a rising edge; pready is captured on the falling edge before it.
    task automatic tick();
        @(negedge clk);
        rdy_seen = o_m_pready;
        @(posedge clk);
        #1;
    endtask

    task automatic new_setup(input int k);
        m_psel[k]             = 1'b1;
        m_penable[k]          = 1'b0;
        m_pwrite[k]           = 1'($urandom_range(0, 1));
        m_paddr[k*AW +: AW]   = AW'($urandom_range(0, 15) * 4);
        m_pwdata[k*DW +: DW]  = DW'($urandom);
    endtask

    // One APB3 master step each: hold until pready, then continue or go idle.
    task automatic drive_masters(input logic [1:0] want, input bit viol);
        for (int k = 0; k < 2; k++) begin
            if (m_psel[k] && rdy_seen[k]) begin
                if (want[k]) new_setup(k);
                else begin
                    m_psel[k]    = 1'b0;
                    m_penable[k] = 1'b0;
                end
            end else if (m_psel[k]) begin
                if (viol && m_penable[k] && $urandom_range(0, 63) == 0) begin
                    m_psel[k]    = 1'b0;
                    m_penable[k] = 1'b0;
                end else begin
                    m_penable[k] = 1'b1;
                end
            end else if (want[k]) begin
                new_setup(k);
            end
        end
    endtask

    task automatic drain();
        s_pready  = 1'b1;
        s_pslverr = 1'b0;
        for (int c = 0; c < 40 && (m_psel != 2'b00 || o_busy); c++) begin
            drive_masters(2'b00, 1'b0);
            s_prdata = DW'($urandom);
            tick();
        end
        chk("drain_idle", {m_psel, o_busy}, 3'b000);
        s_pready = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        m_psel    = '0;
        m_penable = '0;
        s_pready  = 1'b0;
        s_pslverr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [1:0] got [6];
        logic [1:0] prev;
        int         n;
        for (int i = 0; i < 6; i++) got[i] = 2'b00;

        // ---- reset values ----
        tick();
        #1;
        chk("rst_grant",  o_grant,    2'b00);
        chk("rst_busy",   o_busy,     1'b0);
        chk("rst_s_psel", o_s_psel,   1'b0);
        chk("rst_pready", o_m_pready, 2'b00);
        tick();
        rst = 1'b0;
        tick();

        // ---- M0 write 0x08 / 0x1F4, slave with registered pready ----
        m_psel = 2'b01; m_penable = 2'b00; m_pwrite = 2'b01;
        m_paddr[0 +: AW] = 32'h08; m_pwdata[0 +: DW] = 32'h0000_01F4;
        #1;
        chk("t1_c0_spsel", o_s_psel, 1'b0);
        tick();
        m_penable = 2'b01;
        #1;
        chk("t1_c1_spsel",  o_s_psel,    1'b1);
        chk("t1_c1_spen",   o_s_penable, 1'b0);
        chk("t1_c1_grant",  o_grant,     2'b01);
        chk("t1_c1_paddr",  o_s_paddr,   32'h08);
        chk("t1_c1_pwdata", o_s_pwdata,  32'h0000_01F4);
        chk("t1_c1_pwrite", o_s_pwrite,  1'b1);
        tick();
        #1;
        chk("t1_c2_spen", o_s_penable, 1'b1);
        chk("t1_c2_rdy",  o_m_pready,  2'b00);
        tick();
        s_pready = 1'b1; s_prdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_c3_rdy",     o_m_pready,            2'b01);
        chk("t1_c3_m1_data", o_m_prdata[DW +: DW],  32'h0);
        tick();
        m_psel = 2'b00; m_penable = 2'b00; s_pready = 1'b0;
        #1;
        chk("t1_c4_busy",  o_busy,    1'b0);
        chk("t1_c4_paddr", o_s_paddr, 32'h0);

        // ---- simultaneous reads right after reset ----
        do_reset();
        m_psel = 2'b11; m_penable = 2'b00; m_pwrite = 2'b00;
        m_paddr = {32'h0C, 32'h04};
        tick();
        m_penable = 2'b11;
        #1;
        chk("t2_first_grant", o_grant, 2'b01);
        tick();
        s_pready = 1'b1; s_prdata = 32'hAAAA_0001;
        #1;
        chk("t2_rdy0",   o_m_pready, 2'b01);
        chk("t2_rdata0", o_m_prdata, {32'h0, 32'hAAAA_0001});
        tick();
        m_psel = 2'b10; m_penable = 2'b10; s_pready = 1'b0;
        #1;
        chk("t2_gap_busy", o_busy, 1'b0);
        tick();
        #1;
        chk("t2_second_grant", o_grant,   2'b10);
        chk("t2_addr1",        o_s_paddr, 32'h0C);
        tick();
        s_pready = 1'b1; s_prdata = 32'h5555_000F;
        #1;
        chk("t2_rdy1",   o_m_pready, 2'b10);
        chk("t2_rdata1", o_m_prdata, {32'h5555_000F, 32'h0});
        tick();
        m_psel = 2'b00; m_penable = 2'b00; s_pready = 1'b0;
        tick();

        // ---- continuous contention: grant order alternates from M0 ----
        s_pready = 1'b1; s_pslverr = 1'b0;
        n = 0; prev = 2'b00;
        for (int c = 0; c < 80 && n < 6; c++) begin
            drive_masters(2'b11, 1'b0);
            s_prdata = DW'($urandom);
            #1;
            if (o_grant != 2'b00 && prev == 2'b00) begin
                got[n] = o_grant;
                n++;
            end
            prev = o_grant;
            tick();
        end
        chk("rr_count", n, 6);
        for (int i = 0; i < 6; i++) chk("rr_order", got[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        drain();

        // ---- M1 write to read-only 0x10, slave error ----
        m_psel = 2'b10; m_penable = 2'b00; m_pwrite = 2'b10;
        m_paddr[AW +: AW] = 32'h10; m_pwdata[DW +: DW] = 32'h0000_0055;
        tick();
        m_penable = 2'b10;
        tick();
        s_pready = 1'b1; s_pslverr = 1'b1; s_prdata = 32'h0;
        #1;
        chk("t4_rdy", o_m_pready,  2'b10);
        chk("t4_err", o_m_pslverr, 2'b10);
        tick();
        m_psel = 2'b00; m_penable = 2'b00; s_pready = 1'b0; s_pslverr = 1'b0;
        tick();

        // ---- reset during ACCESS of an M0 transfer ----
        m_psel = 2'b01; m_penable = 2'b00; m_pwrite = 2'b00; m_paddr[0 +: AW] = 32'h00;
        tick();
        m_penable = 2'b01;
        tick();
        s_pready = 1'b1;
        tick();
        m_psel = 2'b00; m_penable = 2'b00; s_pready = 1'b0;
        tick();
        m_psel = 2'b01; m_penable = 2'b00; m_paddr[0 +: AW] = 32'h04;
        tick();
        m_penable = 2'b01;
        tick();
        #1;
        chk("t5_in_access", o_s_penable, 1'b1);
        #1;
        rst = 1'b1; m_psel = 2'b00; m_penable = 2'b00;
        #1;
        chk("t5_rst_spsel", o_s_psel,    1'b0);
        chk("t5_rst_spen",  o_s_penable, 1'b0);
        chk("t5_rst_rdy",   o_m_pready,  2'b00);
        chk("t5_rst_grant", o_grant,     2'b00);
        tick();
        rst = 1'b0;
        tick();
        m_psel = 2'b11; m_penable = 2'b00; m_pwrite = 2'b00;
        tick();
        #1;
        chk("t5_grant_after_rst", o_grant, 2'b01);
        drain();

        // ---- slave never ready: transfer stays pending ----
        m_psel = 2'b01; m_penable = 2'b00;
        tick();
        m_penable = 2'b01; s_pready = 1'b0;
        repeat (80) tick();
        #1;
        chk("t6_busy_hold", o_busy,      1'b1);
        chk("t6_spen_hold", o_s_penable, 1'b1);
        chk("t6_no_rdy",    o_m_pready,  2'b00);
        drain();

        // ---- randomized traffic, including abandoned transfers ----
        for (int c = 0; c < 2000; c++) begin
            drive_masters({1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)}, 1'b1);
            s_pready  = ($urandom_range(0, 2) == 0);
            s_pslverr = 1'($urandom_range(0, 1));
            s_prdata  = DW'($urandom);
            tick();
        end
        drain();

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
